hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised successor to the single-case load-use detector in the decode stage. It keeps a per-register countdown of cycles until each destination register's value is consumable, and from that decides stall/bubble for the instruction in ID. It supports any load latency, any writeback distance, and machines with or without a forwarding network. It sits in ID, between the decoder and the ID/EX pipeline register, and also keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- NREG, 32, number of architectural registers; register 0 is hardwired zero.
- AW, 5, register address width; must satisfy 2**AW >= NREG.
- LOAD_LAT, 1, cycles a load result is unavailable to a directly following consumer, with forwarding.
- WB_DIST, 3, cycles from ID issue until the register file returns the written value, without forwarding; must be >= LOAD_LAT.
- PERF_W, 16, width of the stall counter.

Ports:
- clk, input, 1, sole clock, rising edge.
- reset, input, 1, asynchronous, active-high.
- id_valid, input, 1, the ID stage holds a real instruction.
- id_rs / id_rt, input, AW, source register addresses.
- id_use_rs / id_use_rt, input, 1, the instruction actually reads rs / rt.
- id_wr, input, 1, the instruction writes a register.
- id_wr_addr, input, AW, destination register (already RegDst-resolved).
- id_is_load, input, 1, the instruction is a memory read.
- flush, input, 1, branch/jump redirect; kill the instruction in ID.
- stall, output, 1, hold PC and IF/ID this cycle.
- bubble, output, 1, load zeros into ID/EX this cycle.
- issue, output, 1, the instruction in ID advances and is recorded.
- stall_cycles, output, PERF_W, saturating count of stall cycles.

## Operation
- State: cnt[r] for r in 1..NREG-1. Width is clog2(WB_DIST+1). Register 0 has no counter and always reads ready.
- A register r is busy when cnt[r] != 0.
- hazard = id_valid & ((id_use_rs & busy(id_rs)) | (id_use_rt & busy(id_rt))).
- stall = hazard & ~flush.
- bubble = stall | flush.
- issue = id_valid & ~hazard & ~flush.
- Per cycle, every nonzero counter decrements by 1.
- On issue with id_wr and id_wr_addr != 0, cnt[id_wr_addr] is loaded with the issue value (see Configuration). The load takes priority over that register's decrement in the same cycle.
- Write-after-write: a new issue overwrites the remaining count, even when the new count is smaller; the youngest producer governs.
- Flush: the ID instruction is not recorded. Counters from already-issued instructions keep counting.
- Flush and hazard in the same cycle: flush wins, and stall is 0.
- An address >= NREG is treated as ready and is never recorded.
- stall_cycles increments on each cycle with stall=1 and holds at all-ones.

## Timing
- stall, bubble and issue are combinational from the inputs and the current counters. There is no added latency.
- Counter updates take effect at the next rising edge.
- Example with FWD (LOAD_LAT=1): load r5 issues at cycle t, so cnt[5]=1 at t+1. A consumer of r5 stalls at t+1 and issues at t+2, giving exactly one bubble.
- In general, an immediately following consumer stalls for the issue value number of cycles.
- Reset, asynchronous at any time: all cnt=0, stall_cycles=0. The outputs are then stall=0, bubble=flush, issue=id_valid & ~flush.
- Reset asserted mid-stall releases the stall immediately.

## Configuration
- HAZARD_SCOREBOARD_FWD_EN defined (forwarding present): a load issues with value LOAD_LAT and a non-load write issues with value 0. Only loads ever stall.
- Not defined (no forwarding network): every register write issues with value WB_DIST. Any read-after-write within WB_DIST cycles stalls.

## Structure
- The shared package cpu_pkg holds the register-address width constant, the REG_ZERO constant, and the latency-calculation function used for the counter width.
- One natural sub-module, sb_counter: a single down-counter with load-priority and a busy output, instantiated NREG-1 times in a generate loop.
- The top level holds the decode/select logic and the performance counter.

## Test plan
- FWD_EN, LOAD_LAT=1: issue lw r5, then add r6,r5,r1 -> exactly 1 stall cycle; bubble=1 in that cycle; add issues on the second cycle; stall_cycles=1.
- FWD_EN, LOAD_LAT=2: issue lw r5, then a consumer of r5 -> 2 stall cycles. With one independent instruction between them -> 1 stall cycle.
- FWD_EN undefined, WB_DIST=3: issue add r7, then sub r8,r7,r7 -> 3 stall cycles. The same pair with two unrelated instructions between them -> 1 stall cycle.
- lw r0 followed by a consumer of r0 -> 0 stalls. lw r5 followed by a consumer with id_use_rs=0 and id_rs=5 -> 0 stalls.
- Hazard present with flush=1 in the same cycle -> stall=0, bubble=1, issue=0, no counter change. A later consumer sees the older producer's remaining count.
- Assert reset while cnt[5]=2 and the consumer is stalling -> stall drops to 0 the same cycle, stall_cycles=0. Separately, force 2**PERF_W+5 stall cycles -> stall_cycles holds at all-ones.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants: register-address width, the zero register, and the
// scoreboard counter-width helper.
package cpu_pkg;

   localparam int unsigned REG_AW = 5;
   localparam logic [REG_AW-1:0] REG_ZERO = '0;

   // Bits needed to hold a countdown from lat down to 0
   function automatic int unsigned cnt_width(input int unsigned lat);
      return (lat < 1) ? 1 : $clog2(lat + 1);
   endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage scoreboard bus: decoded instruction fields in, stall/bubble/issue out.
interface hazard_scoreboard_if #(
   parameter int unsigned AW     = 5,
   parameter int unsigned PERF_W = 16
);
   logic          id_valid;
   logic [AW-1:0] id_rs;
   logic [AW-1:0] id_rt;
   logic          id_use_rs;
   logic          id_use_rt;
   logic          id_wr;
   logic [AW-1:0] id_wr_addr;
   logic          id_is_load;
   logic          flush;
   logic          stall;
   logic          bubble;
   logic          issue;
   logic [PERF_W-1:0] stall_cycles;

   modport master (
      output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
             id_wr, id_wr_addr, id_is_load, flush,
      input  stall, bubble, issue, stall_cycles
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
             id_wr, id_wr_addr, id_is_load, flush,
      output stall, bubble, issue, stall_cycles
   );
endinterface

// File: rtl/hazard_scoreboard_sb_counter.sv
// One register's readiness countdown: load wins over decrement, busy while nonzero.
module sb_counter #(
   parameter int unsigned CW = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   output logic          busy_c
);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)              cnt <= '0;
      else if (load)          cnt <= load_val;
      else if (cnt != '0)     cnt <= cnt - CW'(1);
   end

   assign busy_c = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard with per-register countdowns and a saturating stall counter.
// Define HAZARD_SCOREBOARD_FWD_EN when a forwarding network exists (only loads stall).
module hazard_scoreboard
   import cpu_pkg::*;
#(
   parameter int unsigned NREG     = 32,
   parameter int unsigned AW       = REG_AW,
   parameter int unsigned LOAD_LAT = 1,
   parameter int unsigned WB_DIST  = 3,
   parameter int unsigned PERF_W   = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   hazard_scoreboard_if.slave   sb
);

   localparam int unsigned CW    = cnt_width(WB_DIST);
   localparam int unsigned NSLOT = 1 << AW;

   logic [CW-1:0]    issue_val;
   logic [NSLOT-1:0] busy_vec;
   logic             hazard_c;
   logic             rec_en_c;

`ifdef HAZARD_SCOREBOARD_FWD_EN
   assign issue_val = sb.id_is_load ? CW'(LOAD_LAT) : '0;
`else
   // Without forwarding every write waits for the register file; never shorter than a load
   localparam int unsigned WB_VAL = (WB_DIST > LOAD_LAT) ? WB_DIST : LOAD_LAT;
   logic unused_is_load;
   assign unused_is_load = sb.id_is_load;
   assign issue_val      = CW'(WB_VAL);
`endif

   assign hazard_c = sb.id_valid &
                     ((sb.id_use_rs & busy_vec[sb.id_rs]) |
                      (sb.id_use_rt & busy_vec[sb.id_rt]));

   assign sb.stall  = hazard_c & ~sb.flush;
   assign sb.bubble = sb.stall | sb.flush;
   assign sb.issue  = sb.id_valid & ~hazard_c & ~sb.flush;

   assign rec_en_c = sb.issue & sb.id_wr & (sb.id_wr_addr != AW'(REG_ZERO));

   // r0 and addresses beyond NREG have no counter and always read ready
   for (genvar r = 0; r < NSLOT; r++) begin : g_reg
      if (r == 0 || r >= NREG) begin : g_ready
         assign busy_vec[r] = 1'b0;
      end else begin : g_cnt
         sb_counter #(.CW(CW)) u_cnt (
            .clk      (clk),
            .reset    (reset),
            .load     (rec_en_c && (sb.id_wr_addr == AW'(r))),
            .load_val (issue_val),
            .busy_c   (busy_vec[r])
         );
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         sb.stall_cycles <= '0;
      else if (sb.stall && (sb.stall_cycles != {PERF_W{1'b1}}))
         sb.stall_cycles <= sb.stall_cycles + PERF_W'(1);
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: timestamp-based readiness model,
// directed pipeline sequences and randomized decode traffic.
module tb_hazard_scoreboard;

   localparam int unsigned NREG     = 24;
   localparam int unsigned AW       = 5;
   localparam int unsigned LOAD_LAT = 2;
   localparam int unsigned WB_DIST  = 3;
   localparam int unsigned PERF_W   = 8;
   localparam int          PERF_MAX = (1 << PERF_W) - 1;

`ifdef HAZARD_SCOREBOARD_FWD_EN
   localparam int EXP_A = 2, EXP_B = 1, EXP_C = 0, EXP_D = 0, EXP_G = 1;
`else
   localparam int EXP_A = 3, EXP_B = 2, EXP_C = 3, EXP_D = 1, EXP_G = 2;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b1;

   hazard_scoreboard_if #(.AW(AW), .PERF_W(PERF_W)) hs ();

   hazard_scoreboard #(
      .NREG(NREG), .AW(AW), .LOAD_LAT(LOAD_LAT), .WB_DIST(WB_DIST), .PERF_W(PERF_W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .sb    (hs.slave)
   );

   always #5 clk = ~clk;

   int ncmp  = 0;
   int nfail = 0;

   // Model: absolute cycle at which each register becomes consumable
   longint cyc = 0;
   longint ready_at [NREG];
   int     perf_m = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      ncmp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   function automatic bit m_busy(input logic [AW-1:0] a);
      int ai;
      ai = int'(a);
      if (ai == 0 || ai >= int'(NREG)) return 1'b0;
      return cyc < ready_at[ai];
   endfunction

   function automatic bit m_hazard();
      return hs.id_valid && ((hs.id_use_rs && m_busy(hs.id_rs)) ||
                             (hs.id_use_rt && m_busy(hs.id_rt)));
   endfunction

   function automatic int m_val();
`ifdef HAZARD_SCOREBOARD_FWD_EN
      return hs.id_is_load ? int'(LOAD_LAT) : 0;
`else
      return int'(WB_DIST);
`endif
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(NREG); i++) ready_at[i] <= 0;
         perf_m <= 0;
      end else begin
         if (m_hazard() && !hs.flush && perf_m < PERF_MAX)
            perf_m <= perf_m + 1;
         if (hs.id_valid && !m_hazard() && !hs.flush && hs.id_wr &&
             hs.id_wr_addr != 0 && int'(hs.id_wr_addr) < int'(NREG))
            ready_at[int'(hs.id_wr_addr)] <= cyc + 1 + longint'(m_val());
         cyc <= cyc + 1;
      end
   end

   always @(negedge clk) begin
      chk("stall",        64'(hs.stall),        64'(m_hazard() && !hs.flush));
      chk("bubble",       64'(hs.bubble),       64'((m_hazard() && !hs.flush) || hs.flush));
      chk("issue",        64'(hs.issue),        64'(hs.id_valid && !m_hazard() && !hs.flush));
      chk("stall_cycles", 64'(hs.stall_cycles), 64'(perf_m));
   end

   task automatic set_instr(input int rs, input int rt, input bit urs, input bit urt,
                            input bit wr, input int wa, input bit ld, input bit fl);
      hs.id_valid   = 1'b1;
      hs.id_rs      = AW'(rs);
      hs.id_rt      = AW'(rt);
      hs.id_use_rs  = urs;
      hs.id_use_rt  = urt;
      hs.id_wr      = wr;
      hs.id_wr_addr = AW'(wa);
      hs.id_is_load = ld;
      hs.flush      = fl;
   endtask

   task automatic idle(input int n);
      hs.id_valid = 1'b0;
      hs.flush    = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Present one instruction, hold it until it issues, return its stall-cycle count
   task automatic run_instr(input int rs, input int rt, input bit urs, input bit urt,
                            input bit wr, input int wa, input bit ld, output int nst);
      bit done;
      set_instr(rs, rt, urs, urt, wr, wa, ld, 1'b0);
      nst  = 0;
      done = 1'b0;
      for (int k = 0; k < 64 && !done; k++) begin
         @(negedge clk);
         if (hs.issue) done = 1'b1;
         else if (hs.stall) nst++;
      end
      if (!done) chk("issue_timeout", 64'(0), 64'(1));
      @(posedge clk);
      #1;
      hs.id_valid = 1'b0;
   endtask

   initial begin
      int n;
      hs.id_valid = 1'b0; hs.id_rs = '0; hs.id_rt = '0; hs.id_use_rs = 1'b0;
      hs.id_use_rt = 1'b0; hs.id_wr = 1'b0; hs.id_wr_addr = '0;
      hs.id_is_load = 1'b0; hs.flush = 1'b0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      set_instr(5, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      @(negedge clk);
      chk("rst_issue", 64'(hs.issue), 64'(1));
      chk("rst_stall", 64'(hs.stall), 64'(0));
      chk("rst_count", 64'(hs.stall_cycles), 64'(0));
      hs.flush = 1'b1;
      #1;
      chk("rst_flush_bubble", 64'(hs.bubble), 64'(1));
      chk("rst_flush_issue",  64'(hs.issue),  64'(0));
      hs.flush = 1'b0; hs.id_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      idle(2);

      // load then immediate consumer
      run_instr(1, 2, 0, 0, 1, 5, 1, n);
      run_instr(5, 1, 1, 1, 1, 6, 0, n);
      chk("A_load_use", 64'(n), 64'(EXP_A));
      idle(5);

      // load, one independent, consumer
      run_instr(1, 2, 0, 0, 1, 5, 1, n);
      run_instr(1, 2, 1, 1, 1, 20, 0, n);
      run_instr(5, 1, 1, 1, 1, 6, 0, n);
      chk("B_load_gap1", 64'(n), 64'(EXP_B));
      idle(5);

      // ALU producer then consumer on both sources
      run_instr(1, 2, 1, 1, 1, 7, 0, n);
      run_instr(7, 7, 1, 1, 1, 8, 0, n);
      chk("C_alu_use", 64'(n), 64'(EXP_C));
      idle(5);

      run_instr(1, 2, 1, 1, 1, 7, 0, n);
      run_instr(1, 2, 1, 1, 1, 20, 0, n);
      run_instr(2, 1, 1, 1, 1, 21, 0, n);
      run_instr(7, 7, 1, 1, 1, 8, 0, n);
      chk("D_alu_gap2", 64'(n), 64'(EXP_D));
      idle(5);

      // r0 never busy; unused source ignored; out-of-range never recorded
      run_instr(1, 2, 0, 0, 1, 0, 1, n);
      run_instr(0, 0, 1, 1, 1, 6, 0, n);
      chk("E_r0", 64'(n), 64'(0));
      idle(5);
      run_instr(1, 2, 0, 0, 1, 5, 1, n);
      run_instr(5, 1, 0, 1, 1, 6, 0, n);
      chk("F_unused_rs", 64'(n), 64'(0));
      idle(5);
      run_instr(1, 2, 0, 0, 1, 28, 1, n);
      run_instr(28, 28, 1, 1, 1, 6, 0, n);
      chk("I_out_of_range", 64'(n), 64'(0));
      idle(5);

      // hazard with flush: killed, producer keeps counting
      run_instr(1, 2, 0, 0, 1, 5, 1, n);
      set_instr(5, 1, 1, 1, 1, 5, 0, 1'b1);
      @(negedge clk);
      chk("G_flush_stall",  64'(hs.stall),  64'(0));
      chk("G_flush_bubble", 64'(hs.bubble), 64'(1));
      chk("G_flush_issue",  64'(hs.issue),  64'(0));
      @(posedge clk);
      #1;
      run_instr(5, 1, 1, 1, 1, 6, 0, n);
      chk("G_after_flush", 64'(n), 64'(EXP_G));
      idle(5);

      // async reset in the middle of a stall
      run_instr(1, 2, 0, 0, 1, 5, 1, n);
      set_instr(5, 1, 1, 1, 1, 6, 0, 1'b0);
      @(negedge clk);
      chk("H_stall_before", 64'(hs.stall), 64'(1));
      #2 reset = 1'b1;
      #1;
      chk("H_stall_reset", 64'(hs.stall), 64'(0));
      chk("H_count_reset", 64'(hs.stall_cycles), 64'(0));
      chk("H_issue_reset", 64'(hs.issue), 64'(1));
      @(posedge clk);
      #1;
      reset = 1'b0;
      idle(3);

      // randomized decode traffic, biased toward a few registers
      for (int i = 0; i < 2000; i++) begin
         hs.id_valid   = ($urandom_range(0, 9) < 8);
         hs.id_rs      = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
         hs.id_rt      = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
         hs.id_use_rs  = 1'($urandom_range(0, 1));
         hs.id_use_rt  = 1'($urandom_range(0, 1));
         hs.id_wr      = ($urandom_range(0, 3) != 0);
         hs.id_wr_addr = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
         hs.id_is_load = ($urandom_range(0, 2) == 0);
         hs.flush      = ($urandom_range(0, 9) == 0);
         @(posedge clk);
         #1;
      end
      idle(5);

      // drive the stall counter past saturation
      for (int i = 0; i < 150; i++) begin
         run_instr(1, 2, 0, 0, 1, 5, 1, n);
         run_instr(5, 5, 1, 1, 1, 6, 0, n);
      end
      chk("sat_value", 64'(hs.stall_cycles), 64'(255));
      run_instr(1, 2, 0, 0, 1, 5, 1, n);
      run_instr(5, 5, 1, 1, 1, 6, 0, n);
      chk("sat_hold", 64'(hs.stall_cycles), 64'(255));
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
